fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Decoupling FIFO between the IF stage and the ID stage of the RISC-V pipeline.
- Captures each fetched instruction together with its PC and the BTB prediction (taken flag and target). Presents them to ID through a valid/ready handshake.
- Absorbs ID stalls without stalling instruction fetch until the buffer is full.
- Discards all contents on a pipeline flush (branch mispredict or redirect).

Parameters:
- DATA_WIDTH, 32, width of PC and predicted target.
- INSTR_WIDTH, 32, width of the instruction word.
- DEPTH, 4, number of entries; power of two, at least 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  discard all entries; sampled on the rising edge.
- in_valid  input  1  IF presents an entry.
- in_ready  output  1  buffer can accept an entry.
- in_pc  input  DATA_WIDTH  PC of the fetched instruction.
- in_instr  input  INSTR_WIDTH  fetched instruction.
- in_pred_taken  input  1  BTB hit / predicted taken.
- in_pred_trgt  input  DATA_WIDTH  predicted target.
- out_valid  output  1  head entry available to ID.
- out_ready  input  1  ID consumes the head entry.
- out_pc  output  DATA_WIDTH  head PC.
- out_instr  output  INSTR_WIDTH  head instruction.
- out_pred_taken  output  1  head prediction flag.
- out_pred_trgt  output  DATA_WIDTH  head predicted target.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH-entry circular array.
  - wr_ptr and rd_ptr are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is a separate register.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready. Both are evaluated on the rising edge.
- in_ready = (count < DEPTH). It is purely a function of registered state; there is no combinational dependence on out_ready.
  - A full buffer refuses a push even when a pop happens in the same cycle.
- out_valid = (count != 0).
- out_* fields: head entry (mem[rd_ptr]) when out_valid=1, otherwise forced to all zeros.
- Latency: an entry pushed at edge N is visible on out_* after edge N (one cycle). There is no same-cycle pass-through (see Optional Feature).
- Simultaneous push and pop on a non-empty, non-full buffer: both pointers advance and count is unchanged.
- Push only: count+1. Pop only: count-1. count never exceeds DEPTH and never underflows.
- flush=1 at an edge:
  - rd_ptr, wr_ptr and count are set to 0.
  - Any push or pop in that cycle is ignored; flush has priority over both.
  - After the edge: out_valid=0, in_ready=1.
  - An entry offered in the cycle after flush is accepted normally.
- rst=1 at an edge: same effect as flush.
  - Reset values: count=0, out_valid=0, in_ready=1, out_pc=0, out_instr=0, out_pred_taken=0, out_pred_trgt=0.
  - Storage contents are not cleared; they are masked by out_valid.
- rst has priority over flush. Reset asserted mid-stream drops all entries.
- Entry ordering is strictly FIFO. PC, instruction and prediction fields of one entry always travel together.
- Input fields are captured only on push; they are ignored otherwise.

Optional Feature:
- Macro: FETCH_BUF_BYPASS_EN.
- When defined:
  - If count==0 and in_valid=1, out_valid=1 in the same cycle and out_* equal in_* combinationally.
  - If out_ready=1 in that cycle, the entry is consumed directly. No write, no pointer change, count stays 0.
  - If out_ready=0, the entry is written normally.
  - in_ready is unchanged, and flush/rst still suppress the bypass (out_valid=0 while flush or rst is high).
- When not defined: strict one-cycle latency as above, with no combinational in-to-out path.

Test Plan:
- Reset then idle: after rst pulse, count=0, out_valid=0, in_ready=1, out_pc=0. Push pc=0x100, instr=0x00000013 → next cycle out_valid=1, out_pc=0x100, out_instr=0x00000013.
- Fill with out_ready=0: push PCs 0x0,0x4,0x8,0xC (DEPTH=4) → count=4, in_ready=0. A fifth push (pc=0x10) is refused. Raise out_ready → outputs 0x0,0x4,0x8,0xC in order.
- Streaming wrap: in_valid=out_ready=1 for 10 cycles with PCs 0x0..0x24 step 4 → count stays 1 after the first push; outputs arrive in order, delayed one cycle; pointers wrap without loss.
- Flush mid-stream: 3 entries buffered, flush=1 with in_valid=1 (pc=0x40) → next cycle count=0, out_valid=0. Push pc=0x80 → emerges next.
- Prediction fields: push pc=0x200, pred_taken=1, pred_trgt=0x300 → out_pred_taken=1, out_pred_trgt=0x300 with out_pc=0x200.
- Bypass (FETCH_BUF_BYPASS_EN): empty buffer, in_valid=out_ready=1, pc=0x500 → out_valid=1 and out_pc=0x500 in the same cycle, count remains 0.

Source files
------------

// File: rtl/fetch_buffer.sv
// Fetch buffer: DEPTH-entry FIFO between IF and ID carrying PC, instruction and BTB prediction.
// Optional FETCH_BUF_BYPASS_EN adds a combinational in-to-out path when the buffer is empty.
module fetch_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_pc,
  input  logic [INSTR_WIDTH-1:0]     in_instr,
  input  logic                       in_pred_taken,
  input  logic [DATA_WIDTH-1:0]      in_pred_trgt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_pc,
  output logic [INSTR_WIDTH-1:0]     out_instr,
  output logic                       out_pred_taken,
  output logic [DATA_WIDTH-1:0]      out_pred_trgt,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
  logic                   taken_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]  trgt_mem_q  [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic not_empty;
  logic bypass;
  logic push_en;
  logic pop_en;

  // Handshake: a transfer happens on a rising edge where valid && ready on that side.
  // in_ready depends only on registered occupancy, never on out_ready.
  always_comb begin
    not_empty = (count_q != '0);
    in_ready  = (count_q < DEPTH_C);
`ifdef FETCH_BUF_BYPASS_EN
    bypass    = !not_empty && in_valid && !flush && !rst;
`else
    bypass    = 1'b0;
`endif
    out_valid = not_empty || bypass;
    pop_en    = not_empty && out_ready;
    // A bypassed entry consumed in the same cycle never touches storage.
    push_en   = in_valid && in_ready && !(bypass && out_ready);

    out_pc         = '0;
    out_instr      = '0;
    out_pred_taken = 1'b0;
    out_pred_trgt  = '0;
    if (not_empty) begin
      out_pc         = pc_mem_q[rd_ptr_q];
      out_instr      = instr_mem_q[rd_ptr_q];
      out_pred_taken = taken_mem_q[rd_ptr_q];
      out_pred_trgt  = trgt_mem_q[rd_ptr_q];
    end else if (bypass) begin
      out_pc         = in_pc;
      out_instr      = in_instr;
      out_pred_taken = in_pred_taken;
      out_pred_trgt  = in_pred_trgt;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rst || flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // Storage is not reset; stale contents are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push_en && !rst && !flush) begin
      pc_mem_q[wr_ptr_q]    <= in_pc;
      instr_mem_q[wr_ptr_q] <= in_instr;
      taken_mem_q[wr_ptr_q] <= in_pred_taken;
      trgt_mem_q[wr_ptr_q]  <= in_pred_trgt;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed testbench for fetch_buffer (DEPTH=4) with hand-computed expectations.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_pred_taken;
  logic [31:0] in_pred_trgt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_pred_taken;
  logic [31:0] out_pred_trgt;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  fetch_buffer #(.DATA_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_instr       (in_instr),
    .in_pred_taken  (in_pred_taken),
    .in_pred_trgt   (in_pred_trgt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_pred_taken (out_pred_taken),
    .out_pred_trgt  (out_pred_trgt),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                          input logic taken, input logic [31:0] trgt);
    in_valid      = v;
    in_pc         = pc;
    in_instr      = instr;
    in_pred_taken = taken;
    in_pred_trgt  = trgt;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step(); step();
    rst = 1'b0;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_pc", 64'(out_pc), 64'h0);
    check_eq("rst_out_instr", 64'(out_instr), 64'h0);

    // Single push, one-cycle latency, then pop.
    drive_in(1'b1, 32'h100, 32'h00000013, 1'b0, 32'h0);
    step();
    drive_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_eq("first_valid", 64'(out_valid), 64'd1);
    check_eq("first_pc", 64'(out_pc), 64'h100);
    check_eq("first_instr", 64'(out_instr), 64'h13);
    check_eq("first_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("first_pop_count", 64'(count), 64'd0);
    check_eq("first_pop_valid", 64'(out_valid), 64'd0);
    check_eq("first_pop_pc_zero", 64'(out_pc), 64'h0);

    // Fill to DEPTH with ID stalled.
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b1, 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 32'h0);
      step();
    end
    drive_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_eq("full_count", 64'(count), 64'd4);
    check_eq("full_in_ready", 64'(in_ready), 64'd0);
    check_eq("full_head_pc", 64'(out_pc), 64'h0);
    check_eq("full_head_instr", 64'(out_instr), 64'h1000);
    // Fifth push offered while a pop happens: must be refused.
    drive_in(1'b1, 32'h10, 32'h1004, 1'b0, 32'h0);
    out_ready = 1'b1;
    step();
    drive_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_eq("refuse_count", 64'(count), 64'd3);
    check_eq("drain_pc_4", 64'(out_pc), 64'h4);
    step();
    check_eq("drain_pc_8", 64'(out_pc), 64'h8);
    step();
    check_eq("drain_pc_c", 64'(out_pc), 64'hC);
    check_eq("drain_instr_c", 64'(out_instr), 64'h1003);
    step();
    check_eq("drain_empty_count", 64'(count), 64'd0);
    check_eq("drain_empty_valid", 64'(out_valid), 64'd0);

    // Streaming across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      drive_in(1'b1, 32'(4 * i), 32'h2000 + 32'(i), 1'b0, 32'h0);
      step();
      check_eq($sformatf("stream_count_%0d", i), 64'(count), 64'd1);
      check_eq($sformatf("stream_pc_%0d", i), 64'(out_pc), 64'(4 * i));
      check_eq($sformatf("stream_instr_%0d", i), 64'(out_instr), 64'(32'h2000 + 32'(i)));
    end
    drive_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    out_ready = 1'b0;
    check_eq("stream_end_count", 64'(count), 64'd0);

    // Flush mid-stream, with a push offered in the flush cycle.
    for (int i = 0; i < 3; i++) begin
      drive_in(1'b1, 32'h30 + 32'(4 * i), 32'h3000, 1'b0, 32'h0);
      step();
    end
    check_eq("preflush_count", 64'(count), 64'd3);
    drive_in(1'b1, 32'h40, 32'h4000, 1'b0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_eq("flush_count", 64'(count), 64'd0);
    check_eq("flush_valid", 64'(out_valid), 64'd0);
    check_eq("flush_in_ready", 64'(in_ready), 64'd1);
    check_eq("flush_pc_zero", 64'(out_pc), 64'h0);
    drive_in(1'b1, 32'h80, 32'h8000, 1'b0, 32'h0);
    step();
    drive_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_eq("postflush_pc", 64'(out_pc), 64'h80);
    check_eq("postflush_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Prediction fields travel with their entry.
    drive_in(1'b1, 32'h200, 32'h5000, 1'b1, 32'h300);
    step();
    drive_in(1'b1, 32'h204, 32'h5004, 1'b0, 32'h999);
    step();
    drive_in(1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF);
    check_eq("pred_pc", 64'(out_pc), 64'h200);
    check_eq("pred_taken", 64'(out_pred_taken), 64'd1);
    check_eq("pred_trgt", 64'(out_pred_trgt), 64'h300);
    out_ready = 1'b1;
    step();
    check_eq("pred2_pc", 64'(out_pc), 64'h204);
    check_eq("pred2_taken", 64'(out_pred_taken), 64'd0);
    check_eq("pred2_trgt", 64'(out_pred_trgt), 64'h999);
    step();
    out_ready = 1'b0;
    check_eq("pred_drain_trgt_zero", 64'(out_pred_trgt), 64'h0);

    // Reset mid-stream drops entries and beats flush/push.
    drive_in(1'b1, 32'h600, 32'h6000, 1'b0, 32'h0);
    step(); step();
    check_eq("prerst_count", 64'(count), 64'd2);
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    drive_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_eq("midrst_count", 64'(count), 64'd0);
    check_eq("midrst_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);

    // Empty buffer with an offered entry: bypass or strict latency.
    drive_in(1'b1, 32'h500, 32'h7000, 1'b1, 32'h700);
    out_ready = 1'b1;
    #1;
`ifdef FETCH_BUF_BYPASS_EN
    check_eq("bypass_valid", 64'(out_valid), 64'd1);
    check_eq("bypass_pc", 64'(out_pc), 64'h500);
    check_eq("bypass_trgt", 64'(out_pred_trgt), 64'h700);
    step();
    drive_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_eq("bypass_count", 64'(count), 64'd0);
    check_eq("bypass_after_valid", 64'(out_valid), 64'd0);
`else
    check_eq("nobypass_valid", 64'(out_valid), 64'd0);
    check_eq("nobypass_pc", 64'(out_pc), 64'h0);
    step();
    drive_in(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_eq("nobypass_count", 64'(count), 64'd1);
    check_eq("nobypass_pc_next", 64'(out_pc), 64'h500);
    step();
    check_eq("nobypass_drained", 64'(count), 64'd0);
`endif
    out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
